// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM encoding, the NOP encoding and the bus address alignment helper.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_ADDR = 2'd1,
    FETCH_DATA = 2'd2,
    FETCH_RESP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Instruction reads are always word aligned; misaligned low bits are dropped silently.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Cycle counter for an outstanding fetch; flags the cycle in which the count reaches TIMEOUT_CYCLES-1.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;

  assign count_next = count_q + CNT_W'(1);

  // Expire is looked ahead by one so the abort lands exactly TIMEOUT_CYCLES cycles after acceptance.
  assign expire = run && (count_next == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (run) begin
      count_q <= count_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch responder: turns an inst_fetch pulse into one address/data read on the
// instruction bus and answers with a one-cycle inst_valid. Optional watchdog: FETCH_TIMEOUT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_fetch,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        busy,
  output logic        fetch_error,
  output logic [31:0] ir_addr,
  output logic        ir_addr_valid,
  input  logic        ir_addr_ready,
  input  logic [31:0] ir_data,
  input  logic        ir_data_valid,
  output logic        ir_data_ready
);

  fetch_state_e state;
  fetch_state_e state_next;

  logic accept;
  logic waiting;
  logic data_hs;
  logic expire;

  // All handshake outputs decode straight from the state register, so no bus input reaches an output.
  assign ir_addr_valid = (state == FETCH_ADDR);
  assign ir_data_ready = (state == FETCH_DATA);
  assign inst_valid    = (state == FETCH_RESP);
  assign busy          = (state != FETCH_IDLE);

  assign accept  = (state == FETCH_IDLE) && inst_fetch;
  assign waiting = ir_addr_valid || ir_data_ready;
  assign data_hs = ir_data_ready && ir_data_valid;

`ifdef FETCH_TIMEOUT_EN
  logic err_q;

  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .run   (waiting),
    .expire(expire)
  );

  // A data handshake in the limit cycle completes normally; only a true abort raises the error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= waiting && expire && !data_hs;
    end
  end

  assign fetch_error = err_q;
`else
  logic unused_timeout;

  assign expire         = 1'b0;
  assign fetch_error    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FETCH_IDLE;
    end else begin
      // NOTE: state elements use non-blocking assignment so every register samples pre-edge values.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: default first, so paths that do not assign keep the current state and no latch is inferred.
    state_next = state;
    unique case (state)
      FETCH_IDLE: if (inst_fetch) state_next = FETCH_ADDR;
      FETCH_ADDR: begin
        if (expire) begin
          state_next = FETCH_RESP;
        end else if (ir_addr_ready) begin
          state_next = FETCH_DATA;
        end
      end
      FETCH_DATA: if (ir_data_valid || expire) state_next = FETCH_RESP;
      FETCH_RESP: state_next = FETCH_IDLE;
      default:    state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the instruction holding register is reset too, so a core coming out of reset reads a NOP, not stale data.
      inst    <= INST_NOP;
      ir_addr <= '0;
    end else begin
      if (accept) begin
        ir_addr <= word_align(pc);
      end
      if (data_hs) begin
        inst <= ir_data;
      end else if (waiting && expire) begin
        inst <= INST_NOP;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a bus responder with programmable wait states and a
// latency/content model derived from the fetch protocol rules.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
  localparam int DUT_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 0;
  localparam int DUT_TIMEOUT = 256;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_fetch;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        busy;
  logic        fetch_error;
  logic [31:0] ir_addr;
  logic        ir_addr_valid;
  logic        ir_addr_ready;
  logic [31:0] ir_data;
  logic        ir_data_valid;
  logic        ir_data_ready;

  int checks = 0;
  int errors = 0;

  // Responder configuration and bookkeeping.
  bit          resp_en = 1'b1;
  int          cfg_aw = 0;
  int          cfg_dw = 0;
  int          aw_left = 0;
  int          dw_left = 0;
  bit          pending = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [31:0] reads[$];
  logic [31:0] last_inst = NOP;

  fetch_unit #(
    .TIMEOUT_CYCLES(DUT_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_fetch   (inst_fetch),
    .pc           (pc),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .busy         (busy),
    .fetch_error  (fetch_error),
    .ir_addr      (ir_addr),
    .ir_addr_valid(ir_addr_valid),
    .ir_addr_ready(ir_addr_ready),
    .ir_data      (ir_data),
    .ir_data_valid(ir_data_valid),
    .ir_data_ready(ir_data_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Protocol model: data handshake lands at cycle 2+aw+dw, response one cycle later,
  // unless the watchdog limit cycle (T-1) passes first, which forces a response at cycle T.
  function automatic void predict(input int aw, input int dw, output int cyc, output bit err,
                                  output int nreads);
    int hs;
    hs = 2 + aw + dw;
    if (TB_TIMEOUT > 0 && hs > TB_TIMEOUT - 1) begin
      cyc    = TB_TIMEOUT;
      err    = 1'b1;
      nreads = (1 + aw <= TB_TIMEOUT - 1) ? 1 : 0;
    end else begin
      cyc    = hs + 1;
      err    = 1'b0;
      nreads = 1;
    end
  endfunction

  // Bus responder, acting on the falling edge.
  initial begin
    ir_addr_ready = 1'b0;
    ir_data_valid = 1'b0;
    ir_data       = '0;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        if (!rst || !busy) begin
          ir_addr_ready = 1'b0;
          ir_data_valid = 1'b0;
          pending       = 1'b0;
          aw_left       = cfg_aw;
        end else begin
          if (ir_addr_ready) begin
            ir_addr_ready = 1'b0;
          end else if (ir_addr_valid && !pending) begin
            if (aw_left > 0) begin
              aw_left--;
            end else begin
              ir_addr_ready = 1'b1;
              reads.push_back(ir_addr);
              rd_addr = ir_addr;
              pending = 1'b1;
              dw_left = cfg_dw;
            end
          end
          if (ir_data_valid) begin
            ir_data_valid = 1'b0;
            pending       = 1'b0;
          end else if (pending && ir_data_ready) begin
            if (dw_left > 0) begin
              dw_left--;
            end else begin
              ir_data_valid = 1'b1;
              ir_data       = mem_word(rd_addr);
            end
          end
        end
      end
    end
  end

  // One complete fetch with optional re-pulse while busy and a pulse during the response cycle.
  task automatic run_fetch(input string name, input logic [31:0] pc_v, input int aw, input int dw,
                           input bit repulse);
    int          exp_cyc;
    bit          exp_err;
    int          exp_reads;
    logic [31:0] exp_inst;
    int          n;
    int          base;
    bit          seen;
    predict(aw, dw, exp_cyc, exp_err, exp_reads);
    exp_inst = exp_err ? NOP : mem_word(align(pc_v));
    cfg_aw   = aw;
    cfg_dw   = dw;
    base     = reads.size();
    @(negedge clk);
    inst_fetch = 1'b1;
    pc         = pc_v;
    n          = 0;
    seen       = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      inst_fetch = 1'b0;
      if (repulse && n == 2) begin
        inst_fetch = 1'b1;
        pc         = 32'h0000_0200;
      end
      if (ir_addr_valid) begin
        checks++;
        if (ir_addr !== align(pc_v)) begin
          errors++;
          $display("FAIL %s addr_stable cycle %0d: got %h want %h", name, n, ir_addr, align(pc_v));
        end
      end
      if (inst_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || n != exp_cyc) begin
      errors++;
      $display("FAIL %s latency: got cycle %0d (seen=%0b) want %0d", name, n, seen, exp_cyc);
    end
    checks++;
    if (inst !== exp_inst || fetch_error !== exp_err) begin
      errors++;
      $display("FAIL %s response: got inst %h err %b want inst %h err %b", name, inst, fetch_error,
               exp_inst, exp_err);
    end
    // Pulse during the response cycle must be ignored.
    inst_fetch = 1'b1;
    pc         = 32'h0000_0300;
    @(negedge clk);
    inst_fetch = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || busy !== 1'b0 || fetch_error !== 1'b0 || inst !== exp_inst) begin
      errors++;
      $display("FAIL %s after_resp: got valid %b busy %b err %b inst %h want 0 0 0 %h", name,
               inst_valid, busy, fetch_error, inst, exp_inst);
    end
    checks++;
    if (reads.size() - base != exp_reads ||
        (exp_reads == 1 && reads[reads.size()-1] !== align(pc_v))) begin
      errors++;
      $display("FAIL %s bus_reads: got %0d reads want %0d at %h", name, reads.size() - base,
               exp_reads, align(pc_v));
    end
    last_inst = exp_inst;
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (inst !== NOP || inst_valid !== 1'b0 || busy !== 1'b0 || fetch_error !== 1'b0 ||
        ir_addr !== 32'h0 || ir_addr_valid !== 1'b0 || ir_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s reset_values: got inst %h v %b busy %b err %b addr %h av %b dr %b want %h 0 0 0 0 0 0",
               name, inst, inst_valid, busy, fetch_error, ir_addr, ir_addr_valid, ir_data_ready, NOP);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    inst_fetch = 1'b0;
    pc = '0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    last_inst = NOP;
  endtask

  task automatic test_zero_wait();
    run_fetch("zero_wait", 32'h0000_0100, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_fetch("backpressure", 32'h0000_0100, 4, 3, 1'b0);
  endtask

  task automatic test_repulse();
    run_fetch("repulse", 32'h0000_0100, 0, 2, 1'b1);
  endtask

  task automatic test_misaligned();
    run_fetch("misaligned", 32'h0000_0103, 1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_fetch();
    cfg_aw = 0;
    cfg_dw = 5;
    @(negedge clk);
    inst_fetch = 1'b1;
    pc         = 32'h0000_0180;
    repeat (3) begin
      @(negedge clk);
      inst_fetch = 1'b0;
    end
    checks++;
    if (ir_data_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid in_data: got ir_data_ready %b want 1", ir_data_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset_mid");
    rst = 1'b1;
    last_inst = NOP;
    run_fetch("after_reset", 32'h0000_0104, 0, 0, 1'b0);
  endtask

  task automatic test_spurious_data();
    resp_en = 1'b0;
    @(negedge clk);
    ir_data_valid = 1'b1;
    ir_data       = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (inst !== last_inst || inst_valid !== 1'b0 || ir_data_ready !== 1'b0) begin
        errors++;
        $display("FAIL spurious_data: got inst %h v %b dr %b want %h 0 0", inst, inst_valid,
                 ir_data_ready, last_inst);
      end
    end
    ir_data_valid = 1'b0;
    resp_en = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      run_fetch("random", $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    run_fetch("timeout_addr", 32'h0000_0100, 1000, 0, 1'b0);
    run_fetch("timeout_data", 32'h0000_0140, 1, 1000, 1'b0);
    run_fetch("limit_wins", 32'h0000_0144, 2, 3, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_repulse();
    test_misaligned();
    test_reset_mid_fetch();
    test_spurious_data();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
